// File: rtl/pipe_step_ctrl_pkg.sv
// pipe_step_ctrl_pkg: shared state encodings and counter-width helpers for the step controller
package pipe_step_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    BREAK = 2'b11
  } state_e;
  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int DB_CNT_W = $clog2(DEBOUNCE_CYCLES_DEF + 1);
  function automatic int db_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/pipe_step_ctrl_btn_debounce.sv
// pipe_step_ctrl_btn_debounce: 2-flop synchronizer, stable-sample debounce and registered rising-edge pulse
module pipe_step_ctrl_btn_debounce
  import pipe_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int CW = db_cnt_w(DEBOUNCE_CYCLES);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          lvl_q, prev_q, pulse_q;
  // cnt_q counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      prev_q  <= lvl_q;
      pulse_q <= lvl_q & ~prev_q;
      if (sync_q[1] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_q <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
  assign pulse_o = pulse_q;
endmodule

// File: rtl/pipe_step_ctrl.sv
// pipe_step_ctrl: run/step/breakpoint sequencer producing the pipeline advance enable
module pipe_step_ctrl
  import pipe_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int STEP_N          = 1,
  parameter int PC_W            = 16,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             step_btn,
  input  logic             run_sw,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_pc,
  input  logic [PC_W-1:0]  pc,
  input  logic             clr_cnt,
  output logic             adv,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_count
);
  localparam int SW = (STEP_N > 1) ? $clog2(STEP_N) : 1;
  state_e           state_q, state_d;
  logic [SW-1:0]    ctr_q, ctr_d;
  logic [1:0]       run_sync_q;
  logic             run_prev_q, bp_hit_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_pulse, run_s, run_rise, bp_match;
  pipe_step_ctrl_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk     (clk),
    .resetn  (resetn),
    .btn_i   (step_btn),
    .pulse_o (step_pulse)
  );
  assign run_s    = run_sync_q[1];
  assign run_rise = run_s & ~run_prev_q;
  assign bp_match = bp_en && (pc == bp_pc);
  // combinational so the breakpoint instruction is never fetched past in RUN
  assign adv      = (state_q == STEP) || (state_q == RUN && !bp_match);
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    case (state_q)
      IDLE: begin
        if (halt_req) state_d = IDLE;
        else if (run_s) state_d = RUN;
        else if (step_pulse) begin
          state_d = STEP;
          ctr_d   = SW'(STEP_N - 1);
        end
      end
      RUN: state_d = (halt_req || !run_s) ? IDLE : bp_match ? BREAK : RUN;
      STEP: begin
        if (halt_req || ctr_q == '0) state_d = IDLE;
        else ctr_d = ctr_q - SW'(1);
      end
      BREAK: begin
        if (halt_req || !run_s) state_d = IDLE;
        else if (step_pulse) begin
          state_d = STEP;
          ctr_d   = SW'(STEP_N - 1);
        end else if (run_rise) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  assign cnt_d = clr_cnt ? '0 : (adv && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      ctr_q      <= '0;
      run_sync_q <= '0;
      run_prev_q <= 1'b0;
      bp_hit_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      run_sync_q <= {run_sync_q[0], run_sw};
      run_prev_q <= run_s;
      bp_hit_q   <= (state_d == BREAK);
      cnt_q      <= cnt_d;
    end
  end
  assign state       = state_q;
  assign bp_hit      = bp_hit_q;
  assign cycle_count = cnt_q;
endmodule
